fetch_stage: RTL and testbench

- Instruction-fetch stage with PC register and IF/ID pipeline register.
- Sits directly upstream of the load-use hazard checker; supplies IFIDRs/IFIDRt to it and consumes its datahazard stall.
- Handles a variable-latency instruction memory (req/ready) and branch/jump redirects resolved in ID.

---
 rtl/fetch_stage.sv | 242 ++++++++++++++++++++++++
 tb/tb_fetch_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, IF/ID register and variable-latency imem fetch.
// Define FETCH_DELAY_SLOT_EN for MIPS branch-delay-slot semantics.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        datahazard,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IFIDInstr,
    output logic [31:0] IFIDPCPlus4,
    output logic        IFIDValid,
    output logic [4:0]  IFIDRs,
    output logic [4:0]  IFIDRt
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
`ifdef FETCH_DELAY_SLOT_EN
        DROP  = 2'd2,
        SLOT  = 2'd3
`else
        DROP  = 2'd2
`endif
    } state_t;

    state_t      state;
    state_t      state_d;
    logic [31:0] pc;
    logic [31:0] pc_d;
    logic [31:0] tgt;
    logic [31:0] tgt_d;
    logic [31:0] hbuf;
    logic [31:0] hbuf_d;
    logic [31:0] instr_d;
    logic [31:0] pc4_d;
    logic        valid_d;
    logic        redir;
    logic [31:0] rtarget;
    logic [31:0] pc_plus4;
    logic        load;
    logic        bub;
    logic [31:0] ld_instr;
`ifdef FETCH_DELAY_SLOT_EN
    logic        pend;
    logic        pend_d;
`endif

    // A stalled ID instruction cannot have a valid resolution.
    assign redir     = (branch_taken | jump) & ~datahazard;
    assign rtarget   = branch_taken ? branch_target : jump_target;
    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;
    assign IFIDRs    = IFIDInstr[25:21];
    assign IFIDRt    = IFIDInstr[20:16];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            FETCH: begin
                if (imem_req) begin
                    if (imem_ready) begin
                        if (!redir && datahazard) begin
                            state_d = HOLD;
                        end
                    end else if (redir) begin
`ifdef FETCH_DELAY_SLOT_EN
                        state_d = SLOT;
`else
                        state_d = DROP;
`endif
                    end
                end
            end
            HOLD: begin
                if (!datahazard) begin
                    state_d = FETCH;
                end
            end
            DROP: begin
                if (imem_ready) begin
                    state_d = FETCH;
                end
            end
`ifdef FETCH_DELAY_SLOT_EN
            SLOT: begin
                if (imem_ready) begin
                    state_d = datahazard ? HOLD : FETCH;
                end
            end
`endif
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        pc_d     = pc;
        tgt_d    = tgt;
        hbuf_d   = hbuf;
        load     = 1'b0;
        bub      = 1'b0;
        ld_instr = imem_rdata;
`ifdef FETCH_DELAY_SLOT_EN
        pend_d   = pend;
`endif
        unique case (state)
            FETCH: begin
                // imem_req is low only in the first cycle out of reset.
                if (imem_req) begin
                    if (imem_ready) begin
                        if (redir) begin
`ifdef FETCH_DELAY_SLOT_EN
                            load = 1'b1;
`else
                            bub  = 1'b1;
`endif
                            pc_d = rtarget;
                        end else if (datahazard) begin
                            hbuf_d = imem_rdata;
                        end else begin
                            load = 1'b1;
                            pc_d = pc_plus4;
                        end
                    end else if (redir) begin
                        tgt_d = rtarget;
                        bub   = 1'b1;
                    end else begin
                        bub = ~datahazard;
                    end
                end
            end
            HOLD: begin
                if (!datahazard) begin
                    ld_instr = hbuf;
                    if (redir) begin
`ifdef FETCH_DELAY_SLOT_EN
                        load = 1'b1;
`else
                        bub  = 1'b1;
`endif
                        pc_d = rtarget;
                    end else begin
                        load = 1'b1;
`ifdef FETCH_DELAY_SLOT_EN
                        pc_d = pend ? tgt : pc_plus4;
`else
                        pc_d = pc_plus4;
`endif
                    end
`ifdef FETCH_DELAY_SLOT_EN
                    pend_d = 1'b0;
`endif
                end
            end
            DROP: begin
                bub = ~datahazard;
                if (redir) begin
                    tgt_d = rtarget;
                end
                if (imem_ready) begin
                    pc_d = redir ? rtarget : tgt;
                end
            end
`ifdef FETCH_DELAY_SLOT_EN
            SLOT: begin
                if (redir) begin
                    tgt_d = rtarget;
                end
                if (imem_ready) begin
                    if (datahazard) begin
                        hbuf_d = imem_rdata;
                        pend_d = 1'b1;
                    end else begin
                        load = 1'b1;
                        pc_d = redir ? rtarget : tgt;
                    end
                end else begin
                    bub = ~datahazard;
                end
            end
`endif
            default: ;
        endcase

        instr_d = IFIDInstr;
        pc4_d   = IFIDPCPlus4;
        valid_d = IFIDValid;
        if (load) begin
            instr_d = ld_instr;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
        end else if (bub) begin
            instr_d = NOP_INSTR;
            pc4_d   = 32'd0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            tgt         <= 32'd0;
            hbuf        <= 32'd0;
            IFIDInstr   <= NOP_INSTR;
            IFIDPCPlus4 <= 32'd0;
            IFIDValid   <= 1'b0;
            imem_req    <= 1'b0;
`ifdef FETCH_DELAY_SLOT_EN
            pend        <= 1'b0;
`endif
        end else begin
            pc          <= pc_d;
            tgt         <= tgt_d;
            hbuf        <= hbuf_d;
            IFIDInstr   <= instr_d;
            IFIDPCPlus4 <= pc4_d;
            IFIDValid   <= valid_d;
            imem_req    <= (state_d != HOLD);
`ifdef FETCH_DELAY_SLOT_EN
            pend        <= pend_d;
`endif
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage against hand-computed values.
// Instruction memory word at address a is word(a) below.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        datahazard;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] IFIDInstr;
    logic [31:0] IFIDPCPlus4;
    logic        IFIDValid;
    logic [4:0]  IFIDRs;
    logic [4:0]  IFIDRt;

    int total = 0;
    int fails = 0;

    fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .datahazard    (datahazard),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .IFIDInstr     (IFIDInstr),
        .IFIDPCPlus4   (IFIDPCPlus4),
        .IFIDValid     (IFIDValid),
        .IFIDRs        (IFIDRs),
        .IFIDRt        (IFIDRt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        if (a == 32'd0) return 32'h2001_0005;
        if (a == 32'd4) return 32'h2002_0003;
        return a ^ 32'h8C00_0000;
    endfunction

    always_comb imem_rdata = word(imem_addr);

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        datahazard = 1'b0;
        branch_taken = 1'b0;
        branch_target = 32'd0;
        jump = 1'b0;
        jump_target = 32'd0;
        imem_ready = 1'b1;
        cyc();
        cyc();
        total++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rst_req got %h exp 0", imem_req); end
        total++; if (IFIDValid !== 1'b0) begin fails++; $display("FAIL rst_valid got %h exp 0", IFIDValid); end
        total++; if (IFIDInstr !== 32'd0) begin fails++; $display("FAIL rst_instr got %h exp 0", IFIDInstr); end
        total++; if (IFIDPCPlus4 !== 32'd0) begin fails++; $display("FAIL rst_pc4 got %h exp 0", IFIDPCPlus4); end
        total++; if (imem_addr !== 32'd0) begin fails++; $display("FAIL rst_addr got %h exp 0", imem_addr); end
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        cyc();
        total++; if (imem_req !== 1'b1) begin fails++; $display("FAIL seq_req got %h exp 1", imem_req); end
        total++; if (IFIDValid !== 1'b0) begin fails++; $display("FAIL seq_valid_c1 got %h exp 0", IFIDValid); end
        cyc();
        total++; if (IFIDValid !== 1'b1) begin fails++; $display("FAIL seq_valid_c2 got %h exp 1", IFIDValid); end
        total++; if (IFIDInstr !== 32'h2001_0005) begin fails++; $display("FAIL seq_instr0 got %h exp 20010005", IFIDInstr); end
        total++; if (IFIDPCPlus4 !== 32'd4) begin fails++; $display("FAIL seq_pc4_0 got %h exp 4", IFIDPCPlus4); end
        total++; if (IFIDRs !== 5'd0) begin fails++; $display("FAIL seq_rs0 got %h exp 0", IFIDRs); end
        total++; if (IFIDRt !== 5'd1) begin fails++; $display("FAIL seq_rt0 got %h exp 1", IFIDRt); end
        cyc();
        total++; if (IFIDPCPlus4 !== 32'd8) begin fails++; $display("FAIL seq_pc4_1 got %h exp 8", IFIDPCPlus4); end
        total++; if (IFIDRt !== 5'd2) begin fails++; $display("FAIL seq_rt1 got %h exp 2", IFIDRt); end
        total++; if (imem_addr !== 32'd8) begin fails++; $display("FAIL seq_addr got %h exp 8", imem_addr); end
    endtask

    task automatic test_stall();
        datahazard = 1'b1;
        cyc();
        total++; if (imem_req !== 1'b0) begin fails++; $display("FAIL stall_req1 got %h exp 0", imem_req); end
        total++; if (IFIDInstr !== 32'h2002_0003) begin fails++; $display("FAIL stall_instr1 got %h exp 20020003", IFIDInstr); end
        total++; if (IFIDPCPlus4 !== 32'd8) begin fails++; $display("FAIL stall_pc4_1 got %h exp 8", IFIDPCPlus4); end
        cyc();
        total++; if (imem_req !== 1'b0) begin fails++; $display("FAIL stall_req2 got %h exp 0", imem_req); end
        total++; if (IFIDPCPlus4 !== 32'd8) begin fails++; $display("FAIL stall_pc4_2 got %h exp 8", IFIDPCPlus4); end
        total++; if (imem_addr !== 32'd8) begin fails++; $display("FAIL stall_addr got %h exp 8", imem_addr); end
        datahazard = 1'b0;
        cyc();
        total++; if (IFIDInstr !== 32'h8C00_0008) begin fails++; $display("FAIL stall_rel_instr got %h exp 8c000008", IFIDInstr); end
        total++; if (IFIDPCPlus4 !== 32'h0C) begin fails++; $display("FAIL stall_rel_pc4 got %h exp c", IFIDPCPlus4); end
        total++; if (IFIDValid !== 1'b1) begin fails++; $display("FAIL stall_rel_valid got %h exp 1", IFIDValid); end
        total++; if (imem_req !== 1'b1) begin fails++; $display("FAIL stall_rel_req got %h exp 1", imem_req); end
        total++; if (imem_addr !== 32'h0C) begin fails++; $display("FAIL stall_rel_addr got %h exp c", imem_addr); end
        cyc();
        total++; if (imem_addr !== 32'h10) begin fails++; $display("FAIL stall_next_addr got %h exp 10", imem_addr); end
    endtask

    task automatic test_branch();
        branch_taken = 1'b1;
        branch_target = 32'h40;
        cyc();
        branch_taken = 1'b0;
        total++; if (imem_addr !== 32'h40) begin fails++; $display("FAIL br_addr got %h exp 40", imem_addr); end
`ifdef FETCH_DELAY_SLOT_EN
        total++; if (IFIDValid !== 1'b1) begin fails++; $display("FAIL br_valid got %h exp 1", IFIDValid); end
        total++; if (IFIDInstr !== 32'h8C00_0010) begin fails++; $display("FAIL br_slot got %h exp 8c000010", IFIDInstr); end
`else
        total++; if (IFIDValid !== 1'b0) begin fails++; $display("FAIL br_valid got %h exp 0", IFIDValid); end
        total++; if (IFIDInstr !== 32'd0) begin fails++; $display("FAIL br_bubble got %h exp 0", IFIDInstr); end
`endif
        cyc();
        total++; if (IFIDInstr !== 32'h8C00_0040) begin fails++; $display("FAIL br_tgt_instr got %h exp 8c000040", IFIDInstr); end
        total++; if (IFIDPCPlus4 !== 32'h44) begin fails++; $display("FAIL br_tgt_pc4 got %h exp 44", IFIDPCPlus4); end
    endtask

    task automatic test_jump_wait();
        imem_ready = 1'b0;
        jump = 1'b1;
        jump_target = 32'h80;
        cyc();
        jump = 1'b0;
        total++; if (imem_addr !== 32'h44) begin fails++; $display("FAIL jw_addr1 got %h exp 44", imem_addr); end
        total++; if (imem_req !== 1'b1) begin fails++; $display("FAIL jw_req got %h exp 1", imem_req); end
        total++; if (IFIDValid !== 1'b0) begin fails++; $display("FAIL jw_valid1 got %h exp 0", IFIDValid); end
        cyc();
        total++; if (imem_addr !== 32'h44) begin fails++; $display("FAIL jw_addr2 got %h exp 44", imem_addr); end
        cyc();
        total++; if (imem_addr !== 32'h44) begin fails++; $display("FAIL jw_addr3 got %h exp 44", imem_addr); end
        imem_ready = 1'b1;
        cyc();
        total++; if (imem_addr !== 32'h80) begin fails++; $display("FAIL jw_addr_tgt got %h exp 80", imem_addr); end
`ifdef FETCH_DELAY_SLOT_EN
        total++; if (IFIDInstr !== 32'h8C00_0044) begin fails++; $display("FAIL jw_slot got %h exp 8c000044", IFIDInstr); end
`else
        total++; if (IFIDValid !== 1'b0) begin fails++; $display("FAIL jw_discard got %h exp 0", IFIDValid); end
`endif
        cyc();
        total++; if (IFIDInstr !== 32'h8C00_0080) begin fails++; $display("FAIL jw_tgt_instr got %h exp 8c000080", IFIDInstr); end
        total++; if (IFIDPCPlus4 !== 32'h84) begin fails++; $display("FAIL jw_tgt_pc4 got %h exp 84", IFIDPCPlus4); end
    endtask

    task automatic test_hazard_branch();
        datahazard = 1'b1;
        branch_taken = 1'b1;
        branch_target = 32'h200;
        cyc();
        total++; if (imem_addr !== 32'h84) begin fails++; $display("FAIL hb_addr1 got %h exp 84", imem_addr); end
        total++; if (IFIDPCPlus4 !== 32'h84) begin fails++; $display("FAIL hb_pc4_1 got %h exp 84", IFIDPCPlus4); end
        cyc();
        total++; if (imem_addr !== 32'h84) begin fails++; $display("FAIL hb_addr2 got %h exp 84", imem_addr); end
        datahazard = 1'b0;
        branch_taken = 1'b0;
        cyc();
        total++; if (IFIDInstr !== 32'h8C00_0084) begin fails++; $display("FAIL hb_instr got %h exp 8c000084", IFIDInstr); end
        total++; if (imem_addr !== 32'h88) begin fails++; $display("FAIL hb_addr3 got %h exp 88", imem_addr); end
    endtask

    task automatic test_reset_midwait();
        imem_ready = 1'b0;
        cyc();
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (imem_req !== 1'b0) begin fails++; $display("FAIL mr_req got %h exp 0", imem_req); end
        total++; if (IFIDValid !== 1'b0) begin fails++; $display("FAIL mr_valid got %h exp 0", IFIDValid); end
        total++; if (IFIDInstr !== 32'd0) begin fails++; $display("FAIL mr_instr got %h exp 0", IFIDInstr); end
        total++; if (IFIDPCPlus4 !== 32'd0) begin fails++; $display("FAIL mr_pc4 got %h exp 0", IFIDPCPlus4); end
        total++; if (imem_addr !== 32'd0) begin fails++; $display("FAIL mr_addr got %h exp 0", imem_addr); end
        cyc();
        rst_n = 1'b1;
        imem_ready = 1'b1;
        cyc();
        total++; if (imem_req !== 1'b1) begin fails++; $display("FAIL mr_restart_req got %h exp 1", imem_req); end
        total++; if (imem_addr !== 32'd0) begin fails++; $display("FAIL mr_restart_addr got %h exp 0", imem_addr); end
    endtask

    task automatic test_wrap();
        jump = 1'b1;
        jump_target = 32'hFFFF_FFFC;
        cyc();
        jump = 1'b0;
        total++; if (imem_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_addr1 got %h exp fffffffc", imem_addr); end
        cyc();
        total++; if (imem_addr !== 32'd0) begin fails++; $display("FAIL wrap_addr2 got %h exp 0", imem_addr); end
        total++; if (IFIDPCPlus4 !== 32'd0) begin fails++; $display("FAIL wrap_pc4 got %h exp 0", IFIDPCPlus4); end
        total++; if (IFIDInstr !== 32'h73FF_FFFC) begin fails++; $display("FAIL wrap_instr got %h exp 73fffffc", IFIDInstr); end
        total++; if (IFIDValid !== 1'b1) begin fails++; $display("FAIL wrap_valid got %h exp 1", IFIDValid); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_jump_wait();
        test_hazard_branch();
        test_reset_midwait();
        test_wrap();
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
